// File: rtl/key_step_ctrl.sv
// Three-channel debounced pushbutton stepper with auto-run on channel 0.
// Define KEY_STEP_COUNT_EN to build the channel-0 step counter; otherwise step_count reads 16'h0000.
module key_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RUN_DIV         = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  key_n,
    input  logic        run_en,
    output logic [2:0]  step_pulse,
    output logic [2:0]  key_down,
    output logic        run_active,
    output logic [15:0] step_count
);

    localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] DIV_LAST = 24'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t      state_q [3];
    state_t      state_d [3];
    logic [19:0] cnt_q   [3];
    logic [19:0] cnt_d   [3];
    logic [2:0]  sync1_q;
    logic [2:0]  sync2_q;
    logic [2:0]  press;
    logic [2:0]  down_d;
    logic [23:0] div_q;
    logic        auto_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // press[i] marks the PRESS_WAIT->PRESSED edge; registering it gives a pulse aligned with PRESSED
    always_comb begin
        press  = '0;
        down_d = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (sync2_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = PRESSED;
                        press[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 20'd1;
                    end
                end
                PRESSED: begin
                    if (sync2_q[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = PRESSED;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 20'd1;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
            down_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_WAIT);
        end
    end

    assign auto_tick = (div_q == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_active <= 1'b0;
            div_q      <= '0;
        end else begin
            run_active <= run_en;
            if (!run_active || auto_tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 24'd1;
            end
        end
    end

    // Channel 0 switches to the divider while auto-run is active; its FSM keeps tracking the key
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_pulse <= '0;
            key_down   <= '0;
        end else begin
            step_pulse <= {press[2:1], run_active ? auto_tick : press[0]};
            key_down   <= down_d;
        end
    end

`ifdef KEY_STEP_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (step_pulse[0]) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign step_count = count_q;
`else
    assign step_count = '0;
`endif

endmodule

// File: tb/tb_key_step_ctrl.sv
// Directed self-checking bench for key_step_ctrl (DEBOUNCE_CYCLES=4, RUN_DIV=8).
// Key edges reach a pulse/key_down change on the 7th clock edge: 2 sync + 1 IDLE exit + 4 debounce.
module tb_key_step_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  key_n;
    logic        run_en;
    logic [2:0]  step_pulse;
    logic [2:0]  key_down;
    logic        run_active;
    logic [15:0] step_count;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [15:0] exp_cnt  = 16'h0000;

    key_step_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .RUN_DIV         (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .run_en     (run_en),
        .step_pulse (step_pulse),
        .key_down   (key_down),
        .run_active (run_active),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cnt_exp();
`ifdef KEY_STEP_COUNT_EN
        return exp_cnt;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic press_release(input int unsigned ch);
        key_n[ch] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("press_pulse", 32'(step_pulse[ch]), 32'(k == 7));
            chk("press_down", 32'(key_down[ch]), 32'(k >= 7));
            if (k == 7 && ch == 0) exp_cnt = exp_cnt + 16'd1;
        end
        key_n[ch] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("release_pulse", 32'(step_pulse[ch]), 32'd0);
            chk("release_down", 32'(key_down[ch]), 32'(k < 7));
        end
        chk("step_count", 32'(step_count), 32'(cnt_exp()));
    endtask

    initial begin
        reset  = 1'b1;
        key_n  = 3'b111;
        run_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pulse", 32'(step_pulse), 32'd0);
        chk("rst_down", 32'(key_down), 32'd0);
        chk("rst_run", 32'(run_active), 32'd0);
        chk("rst_count", 32'(step_count), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_pulse", 32'(step_pulse), 32'd0);

        // Single clean press on channel 0
        press_release(0);

        // Short bounces on channel 1 never qualify
        for (int k = 0; k < 12; k++) begin
            key_n[1] = ((k / 2) % 2) != 0;
            tick();
            chk("bounce_pulse", 32'(step_pulse[1]), 32'd0);
            chk("bounce_down", 32'(key_down[1]), 32'd0);
        end
        key_n[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("bounce_tail_pulse", 32'(step_pulse[1]), 32'd0);
            chk("bounce_tail_down", 32'(key_down[1]), 32'd0);
        end

        // Auto-run with a manual press that must be suppressed (its press event lands at k=9)
        run_en = 1'b1;
        tick();
        chk("run_active_on", 32'(run_active), 32'd1);
        chk("run_first_pulse", 32'(step_pulse[0]), 32'd0);
        for (int k = 1; k <= 40; k++) begin
            if (k == 3)  key_n[0] = 1'b0;
            if (k == 15) key_n[0] = 1'b1;
            tick();
            chk("auto_pulse", 32'(step_pulse[0]), 32'((k % 8) == 0));
            if ((k % 8) == 0) exp_cnt = exp_cnt + 16'd1;
            if (k == 12) chk("auto_key_down_hi", 32'(key_down[0]), 32'd1);
            if (k == 24) chk("auto_key_down_lo", 32'(key_down[0]), 32'd0);
        end
        run_en = 1'b0;
        tick();
        chk("run_active_off", 32'(run_active), 32'd0);
        chk("auto_count", 32'(step_count), 32'(cnt_exp()));
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("after_run_pulse", 32'(step_pulse), 32'd0);
        end

        // Reset in the middle of auto-run
        run_en = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("mid_run_rst_pulse", 32'(step_pulse), 32'd0);
        chk("mid_run_rst_count", 32'(step_count), 32'd0);
        exp_cnt = 16'h0000;
        run_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("mid_run_post_pulse", 32'(step_pulse), 32'd0);
        chk("mid_run_post_run", 32'(run_active), 32'd0);

        // Reset while channel 2 sits in PRESS_WAIT with the key still held
        key_n[2] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("pw_rst_pulse", 32'(step_pulse), 32'd0);
        tick();
        chk("pw_rst_pulse2", 32'(step_pulse), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("pw_fresh_pulse", 32'(step_pulse[2]), 32'(k == 7));
            chk("pw_fresh_down", 32'(key_down[2]), 32'(k >= 7));
        end
        key_n[2] = 1'b1;
        repeat (8) tick();
        chk("pw_release_down", 32'(key_down[2]), 32'd0);

        // step_count wrap
`ifdef KEY_STEP_COUNT_EN
        @(negedge clk);
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        exp_cnt = 16'hFFFE;
        tick();
        chk("forced_count", 32'(step_count), 32'hFFFE);
`endif
        press_release(0);
        press_release(0);
        press_release(0);

        // Simultaneous presses, staggered releases
        key_n = 3'b000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("simul_pulse", 32'(step_pulse), (k == 7) ? 32'd7 : 32'd0);
            if (k == 7) exp_cnt = exp_cnt + 16'd1;
        end
        chk("simul_down", 32'(key_down), 32'd7);
        key_n[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) key_n[1] = 1'b1;
            if (k == 5) key_n[2] = 1'b1;
            tick();
            chk("stagger_down", 32'(key_down),
                32'({(k < 11), (k < 9), (k < 7)}));
            chk("stagger_pulse", 32'(step_pulse), 32'd0);
        end
        chk("final_count", 32'(step_count), 32'(cnt_exp()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_step_ctrl.md
KEY_STEP_CTRL -- requirements
Module: key_step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable synchronized cycles required to accept a press or release (range 2..2^20-1).
REQ-002 Parameter RUN_DIV, default 5000000, clk cycles between auto-run step pulses (range 2..2^24-1).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 key_n  input  3  raw active-low pushbuttons; [0] step, [1] register-read strobe, [2] memory-read strobe.
REQ-007 run_en  input  1  level; 1 selects auto-run stepping on channel 0.
REQ-008 step_pulse  output  3  one-cycle clean strobes, one per channel; these feed the processor's clk, clk_r and clk_direct inputs.
REQ-009 key_down  output  3  debounced pressed level per channel.
REQ-010 run_active  output  1  registered copy of run_en.
REQ-011 step_count  output  16  number of channel-0 steps issued, for HEX display.

Function
REQ-012 Each key_n bit SHALL pass through a 2-flop synchronizer before any use; sync level 0 means pressed.
REQ-013 Each channel SHALL run an independent FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus a per-channel 20-bit stability counter.
REQ-014 IDLE: sync=0 -> PRESS_WAIT, counter cleared; else stay.
REQ-015 PRESS_WAIT: sync=1 -> IDLE; else counter+1; at counter==DEBOUNCE_CYCLES-1 -> PRESSED.
REQ-016 PRESSED: key_down=1; sync=1 -> RELEASE_WAIT, counter cleared.
REQ-017 RELEASE_WAIT: key_down=1; sync=0 -> PRESSED; counter==DEBOUNCE_CYCLES-1 -> IDLE.
REQ-018 step_pulse[i] SHALL be high for exactly the one cycle following the PRESS_WAIT->PRESSED transition; a held key yields exactly one pulse.
REQ-019 Bounces shorter than DEBOUNCE_CYCLES in either direction SHALL produce no pulse and no key_down change.
REQ-020 Auto-run: while run_active=1, a 24-bit divider counts 0..RUN_DIV-1 and step_pulse[0] is high in the cycle the divider equals RUN_DIV-1, then the divider wraps to 0.
REQ-021 The divider SHALL be held at 0 while run_active=0, so the first auto pulse follows RUN_DIV cycles after run_active rises.
REQ-022 While run_active=1, manual channel-0 pulses SHALL be suppressed; the channel-0 FSM and key_down[0] keep tracking the key.
REQ-023 Channels 1 and 2 SHALL be unaffected by run_en.
REQ-024 step_count SHALL increment by 1 in each cycle step_pulse[0]=1, wrapping 16'hFFFF -> 16'h0000.
REQ-025 All outputs SHALL be registered; no combinational path from key_n or run_en to any output.

Reset
REQ-026 Reset SHALL asynchronously force: all FSMs IDLE, stability counters 0, synchronizers to 1 (released), divider 0, step_pulse 0, key_down 0, run_active 0, step_count 0.
REQ-027 Reset asserted mid-PRESS_WAIT or mid-auto-run SHALL produce no pulse in the reset or first post-reset cycle.
REQ-028 A key held through reset deassertion SHALL be treated as a new press (full debounce, then one pulse).

Configuration
REQ-029 Macro KEY_STEP_COUNT_EN: when defined, step_count behaves per REQ-024; when undefined, the counter is not built and step_count is tied to 16'h0000.

Verification
REQ-030 DEBOUNCE_CYCLES=4; key_n[0] low for 20 cycles, then high -> exactly one 1-cycle step_pulse[0]; key_down[0] high until 4 stable-high cycles after release; step_count=1.
REQ-031 key_n[1] toggles every 2 cycles for 12 cycles, then stays high -> step_pulse[1]=0 and key_down[1]=0 throughout.
REQ-032 RUN_DIV=8, run_en=1 for 40 cycles -> step_pulse[0] at cycles 8, 16, 24, 32, 40 after run_active rises; step_count=5; a key_n[0] press in that window adds no pulse.
REQ-033 Reset pulse while channel 2 is in PRESS_WAIT with key still held -> no pulse during or immediately after reset; one pulse after a fresh 4-cycle debounce.
REQ-034 Force step_count=16'hFFFE, issue 3 channel-0 steps -> 16'hFFFF, 16'h0000, 16'h0001; without KEY_STEP_COUNT_EN step_count stays 16'h0000.
REQ-035 Simultaneous presses on all three keys -> three pulses in the same cycle with independent key_down timing.
